uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART 8N1 receiver. Sits directly downstream of the baud-rate generator (speed_select).
//  - Detects a start-bit falling edge on the serial line and raises bps_start to that generator.
//  - Samples each bit on the generator's mid-bit clk_bps pulse.
//  - Presents the received byte with a one-cycle valid strobe, or flags a framing error.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first (no parity, 1 stop bit)
//  SYNC_STAGES 2   flip-flops in the rs232_rx synchroniser (>=2)
// PORTS
//  clk        in   1          system clock (50 MHz)
//  rst        in   1          asynchronous, active-high reset
//  rs232_rx   in   1          asynchronous serial line, idle high
//  clk_bps    in   1          one-cycle mid-bit sample pulse from the baud generator
//  bps_start  out  1          request to run the baud generator; high for the whole frame
//  rx_data    out  DATA_BITS  last correctly framed byte; held until the next good frame
//  rx_valid   out  1          one-cycle strobe: rx_data updated this cycle
//  frame_err  out  1          one-cycle strobe: stop bit sampled low, byte discarded
//  rx_busy    out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async, immediate): bps_start=0, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
//   Synchroniser and edge-detect flops reset to 1; FSM goes to IDLE. All outputs are registered.
//  Input path: SYNC_STAGES-flop synchroniser, then 1 extra flop. fall = prev & ~curr.
//  FSM states:
//   IDLE: on fall -> START, bps_start<=1 on the same edge. Otherwise stay.
//   START: on clk_bps, sample curr.
//    - 0: go to DATA, bit_cnt<=0.
//    - 1 (glitch / false start): go to IDLE, bps_start<=0, no strobe.
//   DATA: on each clk_bps, shift curr into shift_reg MSB-first-in, so the first bit lands in
//    bit 0 after DATA_BITS shifts.
//    - bit_cnt++ on each sample.
//    - After sample number DATA_BITS (bit_cnt==DATA_BITS-1 at the pulse) -> STOP.
//   STOP: on clk_bps, sample curr; in all cases bps_start<=0 and go to IDLE.
//    - 1: rx_data<=shift_reg and rx_valid<=1 on that same edge.
//    - 0: frame_err<=1; rx_data is unchanged.
//  Latency: rx_valid/frame_err go high 1 clk after the clk_bps pulse that samples the stop bit.
//   bps_start is low in that same cycle.
//  The generator's first clk_bps arrives about half a bit after bps_start rises (mid start bit).
//   Its period is BPS_PARA+1 clk (5208 at 9600 bd).
//  Boundary rules:
//   - fall while not in IDLE is ignored. Line activity between clk_bps pulses is ignored.
//   - clk_bps while in IDLE is ignored.
//   - Back-to-back frames: the falling edge of the next start bit can arrive ~0.5 bit after
//     the STOP sample. IDLE must detect it, so the edge-detect flop keeps running in all states.
//   - Line held low (break): STOP sample = 0, so frame_err. No new frame starts until the
//     line has gone high and then fallen again.
//   - Reset mid-frame: abort immediately, no strobe, bps_start=0. The partial byte is lost
//     and rx_data is cleared.
//   - rx_valid and frame_err are never high in the same cycle. Each is exactly 1 cycle wide.
//   - bit_cnt width = clog2(DATA_BITS)+1. It is not used outside DATA.
// TESTING
//  Setup: clk 50 MHz; baud generator instantiated with BPS_PARA=5207; bit period 5208 clk.
//  1. Send 0x55, then 0xA3, with idle between.
//     -> Each frame gives one rx_valid pulse; rx_data=0x55, then 0xA3; frame_err never set.
//  2. Drive rs232_rx low for 100 clk, then high.
//     -> bps_start rises, then falls 1 clk after the first clk_bps.
//     -> No rx_valid, no frame_err; rx_data unchanged.
//  3. Send 0x3C with the stop bit forced low.
//     -> frame_err pulse for 1 clk; rx_valid stays 0; rx_data keeps its previous value.
//  4. Send 0x00 then 0xFF back-to-back with no idle gap.
//     -> Two rx_valid pulses about 10 bit times apart; data 0x00, then 0xFF.
//  5. Assert rst for 3 clk during data bit 4 of 0x81, then send 0x7E.
//     -> Outputs go to 0 asynchronously; no strobe for the aborted frame.
//     -> rx_data=0x7E with one rx_valid pulse.
//  6. Pulse clk_bps in IDLE with rs232_rx high.
//     -> Stays IDLE; bps_start, rx_busy, rx_valid and frame_err all remain 0.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver: synchronises the serial line, requests the baud generator on a start edge,
// samples each bit on the mid-bit clk_bps pulse and strobes out good bytes or framing errors.
module uart_rx_frame #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   curr;
  logic                   fall;
  logic [CntW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;

  assign curr = sync[SYNC_STAGES-1];
  assign fall = prev & ~curr;

  // Runs in every state so a back-to-back start edge is already tracked when IDLE is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rs232_rx};
      prev <= curr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      bps_start <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (fall) begin
            state     <= StStart;
            bps_start <= 1'b1;
            rx_busy   <= 1'b1;
          end
        end
        StStart: begin
          if (clk_bps) begin
            if (!curr) begin
              state   <= StData;
              bit_cnt <= '0;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state     <= StIdle;
              bps_start <= 1'b0;
              rx_busy   <= 1'b0;
            end
          end
        end
        StData: begin
          if (clk_bps) begin
            shift_reg <= {curr, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + CntW'(1);
            if (bit_cnt == LastBit) begin
              state <= StStop;
            end
          end
        end
        StStop: begin
          if (clk_bps) begin
            state     <= StIdle;
            bps_start <= 1'b0;
            rx_busy   <= 1'b0;
            if (curr) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state     <= StIdle;
          bps_start <= 1'b0;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a small behavioural baud generator (short bit period).
module tb_uart_rx_frame;

  localparam int Bit = 16;

  logic       clk;
  logic       rst;
  logic       rs232_rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  logic       gen_pulse;
  logic       manual_bps;
  int         bcnt;

  int checks;
  int failures;
  int cyc;
  int valid_total;
  int err_total;
  int both_cnt;
  int wide_cnt;
  int prev_stamp;
  int last_stamp;
  logic valid_d;
  logic err_d;

  uart_rx_frame #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs232_rx (rs232_rx),
    .clk_bps  (clk_bps),
    .bps_start(bps_start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Baud generator model: first pulse about half a bit after bps_start rises, then every Bit clk.
  always @(posedge clk) begin
    if (!bps_start) begin
      bcnt      <= 0;
      gen_pulse <= 1'b0;
    end else begin
      bcnt      <= (bcnt == Bit - 1) ? 0 : bcnt + 1;
      gen_pulse <= (bcnt == Bit / 2 - 1);
    end
  end
  assign clk_bps = gen_pulse | manual_bps;

  initial begin
    cyc = 0; valid_total = 0; err_total = 0; both_cnt = 0; wide_cnt = 0;
    prev_stamp = 0; last_stamp = 0; valid_d = 1'b0; err_d = 1'b0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      valid_total = valid_total + 1;
      prev_stamp  = last_stamp;
      last_stamp  = cyc;
    end
    if (frame_err) err_total = err_total + 1;
    if (rx_valid && frame_err) both_cnt = both_cnt + 1;
    if ((rx_valid && valid_d) || (frame_err && err_d)) wide_cnt = wide_cnt + 1;
    valid_d = rx_valid;
    err_d   = frame_err;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rs232_rx = b;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rs232_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];
  int   v0;
  int   e0;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rs232_rx = 1'b1; manual_bps = 1'b0;

    vecs[0] = '{data: 8'h55, stop: 1'b1, gap: 20, exp_valid: 1, exp_err: 0, exp_data: 8'h55};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, gap: 20, exp_valid: 1, exp_err: 0, exp_data: 8'hA3};
    vecs[2] = '{data: 8'h3C, stop: 1'b0, gap: 20, exp_valid: 0, exp_err: 1, exp_data: 8'hA3};
    vecs[3] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_valid: 1, exp_err: 0, exp_data: 8'h00};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, gap: 20, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};

    repeat (3) @(negedge clk);
    check("reset_bps_start", int'(bps_start), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // clk_bps in IDLE with the line high must be ignored.
    v0 = valid_total; e0 = err_total;
    manual_bps = 1'b1;
    @(negedge clk);
    manual_bps = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idle_bps_start", int'(bps_start), 0);
      check("idle_rx_busy", int'(rx_busy), 0);
      @(negedge clk);
    end
    check("idle_strobes", (valid_total - v0) + (err_total - e0), 0);

    for (int k = 0; k < 5; k++) begin
      v0 = valid_total; e0 = err_total;
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].gap);
      check($sformatf("vec%0d_valid_pulses", k), valid_total - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_err_pulses", k), err_total - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
      check($sformatf("vec%0d_bps_start_idle", k), int'(bps_start), 0);
    end
    check("b2b_valid_spacing", last_stamp - prev_stamp, 10 * Bit);

    // Short low glitch: false start, generator released one clk after its first pulse.
    v0 = valid_total; e0 = err_total;
    rs232_rx = 1'b0;
    repeat (4) @(negedge clk);
    rs232_rx = 1'b1;
    for (int i = 0; i < 4 * Bit && !clk_bps; i++) @(negedge clk);
    check("glitch_bps_seen", int'(clk_bps), 1);
    check("glitch_bps_start_high", int'(bps_start), 1);
    @(negedge clk);
    check("glitch_bps_start_low", int'(bps_start), 0);
    check("glitch_rx_busy", int'(rx_busy), 0);
    repeat (2 * Bit) @(negedge clk);
    check("glitch_valid", valid_total - v0, 0);
    check("glitch_err", err_total - e0, 0);
    check("glitch_rx_data", int'(rx_data), 8'hFF);

    // Break: line held low across a whole frame gives one framing error and no restart.
    v0 = valid_total; e0 = err_total;
    rs232_rx = 1'b0;
    repeat (14 * Bit) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (3 * Bit) @(negedge clk);
    check("break_err", err_total - e0, 1);
    check("break_valid", valid_total - v0, 0);
    check("break_bps_start", int'(bps_start), 0);
    check("break_rx_data", int'(rx_data), 8'hFF);

    // Reset during data bit 4 of 0x81.
    v0 = valid_total; e0 = err_total;
    fork
      send_frame(8'h81, 1'b1, 0);
      begin
        repeat (5 * Bit + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_bps_start", int'(bps_start), 0);
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_rx_busy", int'(rx_busy), 0);
        check("midrst_rx_valid", int'(rx_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("midrst_no_valid", valid_total - v0, 0);
    check("midrst_no_err", err_total - e0, 0);
    check("midrst_rx_data_after", int'(rx_data), 0);
    // Synchroniser restarts at 1, so the low line after reset opens a new frame; let it drain.
    repeat (14 * Bit) @(negedge clk);

    v0 = valid_total; e0 = err_total;
    send_frame(8'h7E, 1'b1, 20);
    check("post_rst_valid", valid_total - v0, 1);
    check("post_rst_err", err_total - e0, 0);
    check("post_rst_rx_data", int'(rx_data), 8'h7E);

    check("valid_and_err_same_cycle", both_cnt, 0);
    check("strobe_wider_than_1", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
